zynet_axil_slave: RTL and testbench

- AXI4-Lite responder and register file that terminates the host control bus of the zyNet accelerator.
- Converts host register writes into weight, bias, layer and neuron configuration strobes for the neuron array.
- Latches the classification result and all neuron outputs, and raises a level interrupt when a result is ready.
- Sits between the processor (or the bench bus master) and the network core; it is the responder for the bench's writeAxi/readAxi initiator.

---
 rtl/zynet_axil_pkg.sv | 44 ++++
 rtl/zynet_axil_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_zynet_axil_slave.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zynet_axil_pkg.sv
// Shared constants and helpers for the zyNet AXI4-Lite control slave:
// register offsets, response code, status bit position and byte-lane helpers.
package zynet_axil_pkg;

    localparam int AXIL_ADDR_W = 5;
    localparam int AXIL_DATA_W = 32;

    typedef logic [AXIL_ADDR_W-1:0] axil_addr_t;

    localparam axil_addr_t ADDR_WEIGHT = 5'h00;
    localparam axil_addr_t ADDR_BIAS   = 5'h04;
    localparam axil_addr_t ADDR_RESULT = 5'h08;
    localparam axil_addr_t ADDR_LAYER  = 5'h0C;
    localparam axil_addr_t ADDR_NEURON = 5'h10;
    localparam axil_addr_t ADDR_NOUT   = 5'h14;
    localparam axil_addr_t ADDR_STATUS = 5'h18;
    localparam axil_addr_t ADDR_SRST   = 5'h1C;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int STATUS_DONE_BIT = 0;

    // Byte lanes that together cover the low dw bits of a 32-bit word.
    function automatic logic [3:0] value_lanes(input int dw);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = (i * 8) < dw;
        end
        return m;
    endfunction

    function automatic logic [AXIL_DATA_W-1:0] merge_lanes(
        input logic [AXIL_DATA_W-1:0] old_word,
        input logic [AXIL_DATA_W-1:0] new_word,
        input logic [3:0]             strb
    );
        logic [AXIL_DATA_W-1:0] w;
        for (int i = 0; i < 4; i++) begin
            w[i*8 +: 8] = strb[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/zynet_axil_slave.sv
// AXI4-Lite register slave for the zyNet core: config strobes, result latch, interrupt.
// Optional macro ZYNET_AXIL_WSTRB_EN enables byte-lane gating of register writes.
module zynet_axil_slave
    import zynet_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH         = 16,
    parameter int NUM_OUT            = 10
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            weight_valid,
    output logic                            bias_valid,
    output logic [DATA_WIDTH-1:0]           config_value,
    output logic [31:0]                     config_layer,
    output logic [31:0]                     config_neuron,
    output logic                            soft_reset,
    input  logic                            result_valid,
    input  logic [31:0]                     result_class,
    input  logic [NUM_OUT*DATA_WIDTH-1:0]   result_vec,
    output logic                            intr
);

    localparam int               IDX_W       = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_OUT - 1);
    localparam logic [3:0]       VALUE_LANES = value_lanes(DATA_WIDTH);

    logic                          awready_q, awready_d;
    logic                          bvalid_q, bvalid_d;
    logic                          arready_q, arready_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                          rvalid_q, rvalid_d;
    logic [31:0]                   rdata_q, rdata_d;
    logic                          weight_valid_q, weight_valid_d;
    logic                          bias_valid_q, bias_valid_d;
    logic [DATA_WIDTH-1:0]         config_value_q, config_value_d;
    logic [31:0]                   config_layer_q, config_layer_d;
    logic [31:0]                   config_neuron_q, config_neuron_d;
    logic                          soft_reset_q, soft_reset_d;
    logic                          done_q, done_d;
    logic                          intr_q, intr_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [31:0]                   result_class_q, result_class_d;
    logic [DATA_WIDTH-1:0]         result_vec_q [NUM_OUT];
    logic [DATA_WIDTH-1:0]         result_vec_d [NUM_OUT];

    logic        wr_accept, rd_accept, rd_fire, capture, value_ok;
    logic [3:0]  wr_strb;
    logic [31:0] rd_word;

`ifdef ZYNET_AXIL_WSTRB_EN
    assign wr_strb = s_axi_wstrb;
`else
    logic unused_wstrb;
    assign wr_strb      = 4'hF;
    assign unused_wstrb = ^s_axi_wstrb;
`endif

    assign wr_accept = s_axi_awvalid && s_axi_wvalid && !awready_q && !bvalid_q;
    assign rd_accept = s_axi_arvalid && !arready_q && !rvalid_q;
    assign rd_fire   = arready_q;
    assign capture   = result_valid && !soft_reset_q;
    assign value_ok  = (wr_strb & VALUE_LANES) == VALUE_LANES;

    // Read data is taken from the register state on the edge that raises rvalid.
    always_comb begin
        rd_word = '0;
        case (araddr_q)
            ADDR_RESULT: rd_word = result_class_q;
            ADDR_LAYER:  rd_word = config_layer_q;
            ADDR_NEURON: rd_word = config_neuron_q;
            ADDR_NOUT:   rd_word = {{(32-DATA_WIDTH){1'b0}}, result_vec_q[idx_q]};
            ADDR_STATUS: rd_word[STATUS_DONE_BIT] = done_q;
            ADDR_SRST:   rd_word[0] = soft_reset_q;
            default:     rd_word = '0;
        endcase
    end

    // NOTE: every signal assigned here gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        awready_d       = wr_accept;
        bvalid_d        = bvalid_q;
        weight_valid_d  = 1'b0;
        bias_valid_d    = 1'b0;
        config_value_d  = config_value_q;
        config_layer_d  = config_layer_q;
        config_neuron_d = config_neuron_q;
        soft_reset_d    = soft_reset_q;

        if (awready_q) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (wr_accept) begin
            case (s_axi_awaddr)
                ADDR_WEIGHT: if (value_ok) begin
                    weight_valid_d = 1'b1;
                    config_value_d = s_axi_wdata[DATA_WIDTH-1:0];
                end
                ADDR_BIAS: if (value_ok) begin
                    bias_valid_d   = 1'b1;
                    config_value_d = s_axi_wdata[DATA_WIDTH-1:0];
                end
                ADDR_LAYER:  config_layer_d  = merge_lanes(config_layer_q, s_axi_wdata, wr_strb);
                ADDR_NEURON: config_neuron_d = merge_lanes(config_neuron_q, s_axi_wdata, wr_strb);
                ADDR_SRST:   if (wr_strb[0]) soft_reset_d = s_axi_wdata[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        arready_d      = rd_accept;
        araddr_d       = rd_accept ? s_axi_araddr : araddr_q;
        rvalid_d       = rvalid_q;
        rdata_d        = rdata_q;
        done_d         = done_q;
        idx_d          = idx_q;
        result_class_d = result_class_q;
        result_vec_d   = result_vec_q;
        intr_d         = done_q;

        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            if (araddr_q == ADDR_RESULT) done_d = 1'b0;
            if (araddr_q == ADDR_NOUT)   idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end

        // A new result outranks a same-cycle clear from the host reading 0x08.
        if (capture) begin
            done_d         = 1'b1;
            idx_d          = '0;
            result_class_d = result_class;
            for (int k = 0; k < NUM_OUT; k++) begin
                result_vec_d[k] = result_vec[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        if (soft_reset_q) done_d = 1'b0;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            awready_q       <= 1'b0;
            bvalid_q        <= 1'b0;
            arready_q       <= 1'b0;
            araddr_q        <= '0;
            rvalid_q        <= 1'b0;
            rdata_q         <= '0;
            weight_valid_q  <= 1'b0;
            bias_valid_q    <= 1'b0;
            config_value_q  <= '0;
            config_layer_q  <= '0;
            config_neuron_q <= '0;
            soft_reset_q    <= 1'b1;
            done_q          <= 1'b0;
            intr_q          <= 1'b0;
            idx_q           <= '0;
            result_class_q  <= '0;
            // NOTE: the result store is small and host-readable, so it is reset to keep reads deterministic.
            for (int k = 0; k < NUM_OUT; k++) begin
                result_vec_q[k] <= '0;
            end
        end else begin
            awready_q       <= awready_d;
            bvalid_q        <= bvalid_d;
            arready_q       <= arready_d;
            araddr_q        <= araddr_d;
            rvalid_q        <= rvalid_d;
            rdata_q         <= rdata_d;
            weight_valid_q  <= weight_valid_d;
            bias_valid_q    <= bias_valid_d;
            config_value_q  <= config_value_d;
            config_layer_q  <= config_layer_d;
            config_neuron_q <= config_neuron_d;
            soft_reset_q    <= soft_reset_d;
            done_q          <= done_d;
            intr_q          <= intr_d;
            idx_q           <= idx_d;
            result_class_q  <= result_class_d;
            result_vec_q    <= result_vec_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign weight_valid  = weight_valid_q;
    assign bias_valid    = bias_valid_q;
    assign config_value  = config_value_q;
    assign config_layer  = config_layer_q;
    assign config_neuron = config_neuron_q;
    assign soft_reset    = soft_reset_q;
    assign intr          = intr_q;

endmodule

// File: tb/tb_zynet_axil_slave.sv
// Directed, table-driven bench for zynet_axil_slave (default build, wstrb ignored).
module tb_zynet_axil_slave;
    import zynet_axil_pkg::*;

    localparam int DW = 16;
    localparam int NO = 10;

    logic           clk;
    logic           rst;
    logic [4:0]     s_axi_awaddr;
    logic           s_axi_awvalid;
    logic           s_axi_awready;
    logic [31:0]    s_axi_wdata;
    logic [3:0]     s_axi_wstrb;
    logic           s_axi_wvalid;
    logic           s_axi_wready;
    logic [1:0]     s_axi_bresp;
    logic           s_axi_bvalid;
    logic           s_axi_bready;
    logic [4:0]     s_axi_araddr;
    logic           s_axi_arvalid;
    logic           s_axi_arready;
    logic [31:0]    s_axi_rdata;
    logic [1:0]     s_axi_rresp;
    logic           s_axi_rvalid;
    logic           s_axi_rready;
    logic           weight_valid;
    logic           bias_valid;
    logic [DW-1:0]  config_value;
    logic [31:0]    config_layer;
    logic [31:0]    config_neuron;
    logic           soft_reset;
    logic           result_valid;
    logic [31:0]    result_class;
    logic [NO*DW-1:0] result_vec;
    logic           intr;

    int n_checks = 0;
    int n_fail   = 0;

    logic wv_at, bv_at, wv_after, bv_after;

    zynet_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .DATA_WIDTH(DW),
        .NUM_OUT(NO)
    ) dut (
        .s_axi_aclk(clk),
        .s_axi_areset(rst),
        .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .weight_valid(weight_valid),
        .bias_valid(bias_valid),
        .config_value(config_value),
        .config_layer(config_layer),
        .config_neuron(config_neuron),
        .soft_reset(soft_reset),
        .result_valid(result_valid),
        .result_class(result_class),
        .result_vec(result_vec),
        .intr(intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake did not arrive within the cycle budget", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input int bdelay);
        int n;
        s_axi_awaddr  = a;
        s_axi_wdata   = d;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 20) begin
            tick();
            n++;
        end
        if (!s_axi_awready) begin
            timeout("awready");
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
            return;
        end
        check("wready_with_awready", 32'(s_axi_wready), 32'd1);
        wv_at = weight_valid;
        bv_at = bias_valid;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        wv_after = weight_valid;
        bv_after = bias_valid;
        check("awready_one_cycle", 32'(s_axi_awready), 32'd0);
        check("bvalid_rise", 32'(s_axi_bvalid), 32'd1);
        check("bresp_okay", 32'(s_axi_bresp), 32'(RESP_OKAY));
        for (int i = 0; i < bdelay; i++) begin
            tick();
            check("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("bvalid_clear", 32'(s_axi_bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        int n;
        d = 32'hDEAD_BEEF;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 20) begin
            tick();
            n++;
        end
        if (!s_axi_arready) begin
            timeout("arready");
            s_axi_arvalid = 1'b0;
            return;
        end
        tick();
        s_axi_arvalid = 1'b0;
        check("rvalid_rise", 32'(s_axi_rvalid), 32'd1);
        check("rresp_okay", 32'(s_axi_rresp), 32'(RESP_OKAY));
        d = s_axi_rdata;
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check("rvalid_clear", 32'(s_axi_rvalid), 32'd0);
    endtask

    task automatic pulse_result(input logic [31:0] cls);
        result_class = cls;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
    endtask

    typedef struct {
        logic        is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] rd;
    int          n;

    initial begin
        vecs[0] = '{1'b0, ADDR_SRST,   32'h0,         32'h1};
        vecs[1] = '{1'b0, ADDR_STATUS, 32'h0,         32'h0};
        vecs[2] = '{1'b1, ADDR_LAYER,  32'h2,         32'h0};
        vecs[3] = '{1'b1, ADDR_NEURON, 32'h7,         32'h0};
        vecs[4] = '{1'b0, ADDR_LAYER,  32'h0,         32'h2};
        vecs[5] = '{1'b0, ADDR_NEURON, 32'h0,         32'h7};
        vecs[6] = '{1'b0, ADDR_BIAS,   32'h0,         32'h0};
        vecs[7] = '{1'b0, ADDR_WEIGHT, 32'h0,         32'h0};
        vecs[8] = '{1'b1, ADDR_STATUS, 32'hFFFF_FFFF, 32'h0};
        vecs[9] = '{1'b0, ADDR_STATUS, 32'h0,         32'h0};

        rst           = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = 4'h0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        result_valid  = 1'b0;
        result_class  = '0;
        for (int k = 0; k < NO; k++) begin
            result_vec[k*DW +: DW] = 16'(16'h0100 + k);
        end

        repeat (3) tick();
        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        check("rst_soft_reset", 32'(soft_reset), 32'd1);
        check("rst_intr", 32'(intr), 32'd0);
        check("rst_weight_valid", 32'(weight_valid), 32'd0);
        check("rst_config_layer", config_layer, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, 0);
            end else begin
                axi_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rd_%02h", i, vecs[i].addr), rd, vecs[i].exp);
            end
        end
        check("intr_idle", 32'(intr), 32'd0);

        // Weight write with one-cycle-late bready.
        axi_write(ADDR_WEIGHT, 32'h0000_1234, 1);
        check("weight_strobe", 32'(wv_at), 32'd1);
        check("weight_strobe_once", 32'(wv_after), 32'd0);
        check("weight_no_bias", 32'(bv_at), 32'd0);
        check("weight_value", 32'(config_value), 32'h1234);
        check("cfg_layer", config_layer, 32'd2);
        check("cfg_neuron", config_neuron, 32'd7);

        // Bias write: upper half of wdata is dropped.
        axi_write(ADDR_BIAS, 32'hABCD_5678, 0);
        check("bias_strobe", 32'(bv_at), 32'd1);
        check("bias_strobe_once", 32'(bv_after), 32'd0);
        check("bias_no_weight", 32'(wv_at), 32'd0);
        check("bias_value", 32'(config_value), 32'h5678);

        // Release the core and capture a result.
        axi_write(ADDR_SRST, 32'h0, 0);
        check("soft_reset_low", 32'(soft_reset), 32'd0);
        pulse_result(32'd5);
        check("intr_lags_done", 32'(intr), 32'd0);
        tick();
        check("intr_rise", 32'(intr), 32'd1);
        axi_read(ADDR_RESULT, rd);
        check("rd_result_class", rd, 32'd5);
        check("intr_fall", 32'(intr), 32'd0);
        axi_read(ADDR_STATUS, rd);
        check("rd_status_cleared", rd, 32'd0);

        // Walk the output vector and wrap.
        for (int i = 0; i < 11; i++) begin
            axi_read(ADDR_NOUT, rd);
            check($sformatf("rd_nout_%0d", i), rd, 32'h100 + 32'(i % NO));
        end

        // New result coincident with the 0x08 read side-effect edge.
        pulse_result(32'd9);
        tick();
        check("intr_before_race", 32'(intr), 32'd1);
        s_axi_araddr  = ADDR_RESULT;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 20) begin
            tick();
            n++;
        end
        if (!s_axi_arready) timeout("arready_race");
        result_class = 32'hA;
        result_valid = 1'b1;
        tick();
        result_valid  = 1'b0;
        s_axi_arvalid = 1'b0;
        check("race_rvalid", 32'(s_axi_rvalid), 32'd1);
        check("race_rdata_old_class", s_axi_rdata, 32'd9);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        tick();
        check("race_intr_stays", 32'(intr), 32'd1);
        axi_read(ADDR_STATUS, rd);
        check("race_done_set", rd, 32'd1);
        axi_read(ADDR_RESULT, rd);
        check("race_new_class", rd, 32'hA);

        // Soft reset masks result capture.
        axi_write(ADDR_SRST, 32'h1, 0);
        pulse_result(32'd3);
        tick();
        axi_read(ADDR_STATUS, rd);
        check("srst_blocks_done", rd, 32'd0);
        check("srst_intr_low", 32'(intr), 32'd0);

        // Asynchronous reset while bvalid is pending.
        axi_write(ADDR_SRST, 32'h0, 0);
        s_axi_awaddr  = ADDR_LAYER;
        s_axi_wdata   = 32'h77;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 20) begin
            tick();
            n++;
        end
        if (!s_axi_awready) timeout("awready_rst");
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("pre_rst_bvalid", 32'(s_axi_bvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("async_rst_soft_reset", 32'(soft_reset), 32'd1);
        check("async_rst_layer", config_layer, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        axi_write(ADDR_NEURON, 32'h33, 0);
        axi_read(ADDR_NEURON, rd);
        check("post_rst_write", rd, 32'h33);
        check("post_rst_no_strobe", 32'(weight_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
